// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, scanner FSM encoding and keypad map.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_EMIT,
      ST_HOLD
   } scan_state_t;

   // Key codes: 0-9 are digits, A-D operators, E='*', F='#'.
   localparam logic [3:0] KEY_A    = 4'hA;
   localparam logic [3:0] KEY_B    = 4'hB;
   localparam logic [3:0] KEY_C    = 4'hC;
   localparam logic [3:0] KEY_D    = 4'hD;
   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   // Indexed by {row, col}.
   localparam logic [0:15][3:0] KEYMAP = {
      4'h1, 4'h2, 4'h3, KEY_A,
      4'h4, 4'h5, 4'h6, KEY_B,
      4'h7, 4'h8, 4'h9, KEY_C,
      KEY_STAR, 4'h0, KEY_HASH, KEY_D
   };

   function automatic op_t key_op(input logic [3:0] key);
      case (key)
         KEY_A:   key_op = OP_ADD;
         KEY_B:   key_op = OP_SUB;
         KEY_C:   key_op = OP_MUL;
         default: key_op = OP_DIV;
      endcase
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
   parameter int SCAN_DIV = 50000
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == CW'(SCAN_DIV - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i)       cnt_q <= '0;
      else if (tick_o) cnt_q <= '0;
      else             cnt_q <= cnt_q + 1'b1;
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row drive, column sync, press/release debounce, key decode strobes.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int DEB_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic       is_num,
   output logic       is_op,
   output logic       is_eq,
   output logic       is_clr,
   output logic [3:0] num_val,
   output logic [1:0] op_val
);

   localparam int DW = $clog2(DEB_TICKS + 1);

   logic          tick;
   logic [3:0]    sync1_q, col_s_q;
   scan_state_t   state_q;
   logic [1:0]    row_q, col_q, row_nxt;
   logic [DW-1:0] deb_q;
   logic [3:0]    row_out_q, num_val_q, key;
   logic [1:0]    op_val_q;
   logic          is_num_q, is_op_q, is_eq_q, is_clr_q;
   logic          hit;
   logic [1:0]    hit_col;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk_i (clk),
      .rst_i (rst),
      .tick_o(tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 4'hF;
         col_s_q <= 4'hF;
      end else begin
         sync1_q <= col_in;
         col_s_q <= sync1_q;
      end
   end

   // A valid press pulls exactly one column low; anything else is ignored.
   always_comb begin
      hit     = 1'b1;
      hit_col = 2'd0;
      case (col_s_q)
         4'b1110: hit_col = 2'd0;
         4'b1101: hit_col = 2'd1;
         4'b1011: hit_col = 2'd2;
         4'b0111: hit_col = 2'd3;
         default: hit = 1'b0;
      endcase
   end

   assign row_nxt = row_q + 2'd1;
   assign key     = KEYMAP[{row_q, col_q}];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_SCAN;
         row_q     <= 2'd0;
         row_out_q <= 4'b1110;
         col_q     <= 2'd0;
         deb_q     <= '0;
         is_num_q  <= 1'b0;
         is_op_q   <= 1'b0;
         is_eq_q   <= 1'b0;
         is_clr_q  <= 1'b0;
         num_val_q <= 4'd0;
         op_val_q  <= 2'b00;
      end else begin
         is_num_q <= 1'b0;
         is_op_q  <= 1'b0;
         is_eq_q  <= 1'b0;
         is_clr_q <= 1'b0;
         case (state_q)
            ST_SCAN: if (tick) begin
               if (hit) begin
                  col_q   <= hit_col;
                  deb_q   <= '0;
                  state_q <= ST_DEBOUNCE;
               end else begin
                  row_q     <= row_nxt;
                  row_out_q <= ~(4'b0001 << row_nxt);
               end
            end
            ST_DEBOUNCE: if (tick) begin
               if (col_s_q == ~(4'b0001 << col_q)) begin
                  deb_q <= deb_q + 1'b1;
                  // Strobes are set on entry so they are high exactly during EMIT.
                  if (deb_q == DW'(DEB_TICKS - 1)) begin
                     state_q <= ST_EMIT;
                     if (key <= 4'd9) begin
                        is_num_q  <= 1'b1;
                        num_val_q <= key;
                     end else if (key == KEY_STAR) begin
                        is_clr_q <= 1'b1;
                     end else if (key == KEY_HASH) begin
                        is_eq_q <= 1'b1;
                     end else begin
                        is_op_q  <= 1'b1;
                        op_val_q <= key_op(key);
                     end
                  end
               end else begin
                  state_q <= ST_SCAN;
               end
            end
            ST_EMIT: begin
               deb_q   <= '0;
               state_q <= ST_HOLD;
            end
            ST_HOLD: if (tick) begin
               if (col_s_q == 4'hF) begin
                  if (deb_q == DW'(DEB_TICKS - 1)) begin
                     deb_q   <= '0;
                     state_q <= ST_SCAN;
                  end else begin
                     deb_q <= deb_q + 1'b1;
                  end
               end else begin
                  deb_q <= '0;
               end
            end
            default: state_q <= ST_SCAN;
         endcase
      end
   end

   assign row_out = row_out_q;
   assign is_num  = is_num_q;
   assign is_op   = is_op_q;
   assign is_eq   = is_eq_q;
   assign is_clr  = is_clr_q;
   assign num_val = num_val_q;
   assign op_val  = op_val_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per scan tick (1 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter DEB_TICKS, default 10, consecutive stable ticks required for press and for release; legal range >= 1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 col_in  in  4  keypad columns; asynchronous; active-low, pulled up externally.
REQ-007 row_out  out  4  keypad row drive; exactly one bit low, all others high.
REQ-008 is_num  out  1  one-cycle strobe; a digit key was accepted.
REQ-009 is_op  out  1  one-cycle strobe; an operator key was accepted.
REQ-010 is_eq  out  1  one-cycle strobe; the '#' key was accepted.
REQ-011 is_clr  out  1  one-cycle strobe; the '*' key was accepted.
REQ-012 num_val  out  4  BCD digit 0-9; valid when is_num=1; otherwise holds its last value.
REQ-013 op_val  out  2  operator code; valid when is_op=1; otherwise holds its last value.

Function
REQ-014 col_in SHALL pass through a 2-flop synchronizer; all logic below uses only the synchronized value (colS).
REQ-015 Tick generator: counter 0..SCAN_DIV-1, wraps at the end; tick=1 for one clk cycle when counter=SCAN_DIV-1.
REQ-016 Key map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
REQ-017 Operator codes: A=+ 00, B=- 01, C=* 10, D=/ 11.
REQ-018 FSM states: SCAN, DEBOUNCE, EMIT, HOLD.
REQ-019 SCAN behaviour on tick:
  - exactly one colS bit low: latch row index and column index, clear deb_cnt, go to DEBOUNCE;
  - otherwise: advance row index 0->1->2->3->0 and stay in SCAN.
REQ-020 DEBOUNCE: row is frozen. On each tick:
  - colS equals the latched one-hot-low pattern: increment deb_cnt; when deb_cnt reaches DEB_TICKS, go to EMIT;
  - any other pattern: go to SCAN with row unchanged.
REQ-021 EMIT lasts exactly one clk cycle:
  - assert exactly one of is_num/is_op/is_eq/is_clr per the key map;
  - num_val/op_val are updated in the same cycle as the strobe (registered);
  - next state is HOLD with deb_cnt cleared.
REQ-022 HOLD: row is frozen. On each tick:
  - colS=1111: increment deb_cnt; at DEB_TICKS go to SCAN;
  - any colS bit low: clear deb_cnt.
  - No strobe is generated in HOLD; there is no auto-repeat.
REQ-023 Two or more colS bits low is an invalid press:
  - in SCAN, it is ignored and scanning advances;
  - in DEBOUNCE, it aborts to SCAN.
REQ-024 A key in a different row, pressed while in DEBOUNCE or HOLD, SHALL NOT produce a strobe until HOLD completes and SCAN resumes.
REQ-025 Strobes are mutually exclusive; no two strobes are ever asserted in the same cycle, nor in consecutive cycles.
REQ-026 Latency from a clean, held press to its strobe SHALL be at most (4+DEB_TICKS)*SCAN_DIV+3 clk cycles.

Reset
REQ-027 While rst=1 at a clk edge, the block SHALL load:
  - state=SCAN, row index=0, row_out=1110;
  - tick counter=0, deb_cnt=0;
  - synchronizer flops=1111;
  - all strobes=0, num_val=0, op_val=00.
REQ-028 Reset asserted in any state, including DEBOUNCE, EMIT or HOLD, SHALL abort that state without emitting a strobe. A key still held after reset is treated as a new press and needs a full debounce.

Structure
REQ-029 Package calc_pkg SHALL hold:
  - operator codes OP_ADD/OP_SUB/OP_MUL/OP_DIV;
  - the FSM state encoding;
  - the key-map constants.
  The calculator sequencer shares the same operator codes.
REQ-030 One sub-module, scan_tick_gen, SHALL implement the SCAN_DIV divider.
REQ-031 The synchronizer, FSM and key decode SHALL be implemented inside keypad_scanner.

Verification (SCAN_DIV=4, DEB_TICKS=3)
REQ-032 Reset -> row_out=1110, all strobes 0, num_val=0, op_val=00 on the first cycle after rst falls.
REQ-033 Hold '7' (col0 low whenever row2 is driven) for 200 cycles -> exactly one is_num pulse with num_val=7; no further strobe until after release.
REQ-034 Press 'B', release, then press '#' -> is_op pulse with op_val=01, then an is_eq pulse; is_num stays 0 throughout.
REQ-035 Bounce: hold '5' low for 2 ticks, then release -> no strobe; scanning resumes with row_out rotating.
REQ-036 col_in=1100 held during the row0 drive -> no strobe; row_out keeps rotating 1110,1101,1011,0111.
REQ-037 Pulse rst during HOLD after '3' was accepted, with '3' still held -> no strobe during reset. Exactly one is_num with num_val=3 follows the full debounce after reset.
